obuf_drain: RTL
===============

OBUF_DRAIN -- requirements
Module: obuf_drain

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 11, meaning the width of the output-buffer memory-port word address.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 64, meaning the width of one memory-port data word.
REQ-003 SHALL have parameter LEN_WIDTH, default 12, meaning the width of the transfer word count.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning the number of entries in the internal return FIFO.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic samples on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: request a transfer; accepted only in IDLE.
REQ-008 SHALL have port base_addr, input, MEM_ADDR_WIDTH bits: first word address, sampled when start is accepted.
REQ-009 SHALL have port num_words, input, LEN_WIDTH bits: words to transfer, sampled when start is accepted.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port mem_read_req, output, 1 bit: read strobe to the output buffer memory port.
REQ-013 SHALL have port mem_read_addr, output, MEM_ADDR_WIDTH bits: read address, valid while mem_read_req is high.
REQ-014 SHALL have port mem_read_data, input, MEM_DATA_WIDTH bits: read data, valid exactly one cycle after mem_read_req.
REQ-015 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-016 SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-017 SHALL have port m_data, output, MEM_DATA_WIDTH bits: stream data.
REQ-018 SHALL have port m_last, output, 1 bit: marks the final word of a transfer; qualified by m_valid.

Function
REQ-019 SHALL implement a state machine with states IDLE, ISSUE, DRAIN, FINISH.
REQ-020 SHALL transition from IDLE to ISSUE on start with num_words!=0, latching base_addr and num_words.
REQ-021 SHALL transition from IDLE to FINISH on start with num_words==0 and SHALL issue no reads in that case.
REQ-022 SHALL ignore start in every state other than IDLE, including the FINISH cycle.
REQ-023 SHALL, in ISSUE, assert mem_read_req in a cycle only when (in-flight reads + FIFO occupancy) < FIFO_DEPTH.
REQ-024 SHALL assert the first mem_read_req no earlier than the cycle after start is accepted.
REQ-025 SHALL drive mem_read_addr = base_addr + k for the k-th request (k from 0), wrapping modulo 2^MEM_ADDR_WIDTH.
REQ-026 SHALL assert mem_read_req at most num_words times per transfer.
REQ-027 SHALL transition from ISSUE to DRAIN in the cycle after the final request is issued.
REQ-028 SHALL write mem_read_data into the FIFO in the cycle following each mem_read_req, and SHALL never overflow the FIFO.
REQ-029 SHALL drive m_valid high whenever the FIFO is non-empty.
REQ-030 SHALL hold m_data and m_last stable while m_valid is high and m_ready is low.
REQ-031 SHALL pop one FIFO entry per cycle in which m_valid and m_ready are both high.
REQ-032 SHALL, when the FIFO is empty and a write occurs, assert m_valid no earlier than the following cycle; no combinational path from mem_read_data to m_data.
REQ-033 SHALL support a simultaneous FIFO push and pop in the same cycle, including when the FIFO is full.
REQ-034 SHALL sustain one word per cycle when m_ready is held high.
REQ-035 SHALL assert m_last only with word num_words-1 of the transfer.
REQ-036 SHALL transition from DRAIN to FINISH in the cycle after the m_last handshake.
REQ-037 SHALL assert done for exactly one cycle in FINISH and then return to IDLE.
REQ-038 SHALL keep the word count at LEN_WIDTH bits, so num_words = 2^LEN_WIDTH-1 is the maximum transfer length.

Reset
REQ-039 SHALL, while reset is high, force the state to IDLE, busy=0, done=0, mem_read_req=0, m_valid=0, m_last=0 and FIFO occupancy to 0.
REQ-040 SHALL, when reset is applied during a transfer, discard in-flight data, issue no further reads and leave done unasserted for the aborted transfer.

Verification
REQ-041 Scenario: base_addr=0x010, num_words=4, m_ready=1 -> reads to 0x010..0x013 on consecutive cycles, 4 back-to-back words, m_last on the 4th, one done pulse.
REQ-042 Scenario: base_addr=0x7FE, num_words=4 (MEM_ADDR_WIDTH=11) -> read addresses 0x7FE, 0x7FF, 0x000, 0x001.
REQ-043 Scenario: num_words=8 with m_ready=0 for the first 10 cycles -> exactly 4 reads outstanding or buffered, mem_read_req stalls, no word lost or duplicated, order preserved.
REQ-044 Scenario: num_words=0 -> busy for 1 cycle, done pulse, zero mem_read_req, m_valid stays 0.
REQ-045 Scenario: start pulsed again mid-transfer with different base_addr -> ignored; the original transfer completes unchanged.
REQ-046 Scenario: reset asserted after 2 of 6 words accepted -> all outputs at reset values the next cycle, no done; a new transfer starts cleanly.

Source files
------------

// File: rtl/obuf_drain_if.sv
// Output-buffer drain bus: the memory read port plus the outgoing valid/ready stream.
// master = drain engine side, slave = memory/sink side.
interface obuf_drain_if #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int MEM_DATA_WIDTH = 64
);
    logic                      mem_read_req;
    logic [MEM_ADDR_WIDTH-1:0] mem_read_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_read_data;
    logic                      m_valid;
    logic                      m_ready;
    logic [MEM_DATA_WIDTH-1:0] m_data;
    logic                      m_last;

    modport master (
        output mem_read_req, mem_read_addr, m_valid, m_data, m_last,
        input  mem_read_data, m_ready
    );

    modport slave (
        input  mem_read_req, mem_read_addr, m_valid, m_data, m_last,
        output mem_read_data, m_ready
    );
endinterface

// File: rtl/obuf_drain.sv
// Drains num_words words from the output-buffer memory port into a valid/ready stream.
// A small return FIFO absorbs the one-cycle read latency and sink back-pressure.
module obuf_drain #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int LEN_WIDTH      = 12,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]      num_words,
    output logic                      busy,
    output logic                      done,
    obuf_drain_if.master              bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t                    state, state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]      issue_left;
    logic [LEN_WIDTH-1:0]      out_left;
    logic                      rd_pend;
    logic [MEM_DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0]             wptr, rptr;
    logic [CW-1:0]             count;
    logic                      can_issue, issue, push, pop;

    // A read is only issued if its data is guaranteed a FIFO slot.
    assign can_issue = !reset && ((CW'(rd_pend) + count) < CW'(FIFO_DEPTH));
    assign push      = rd_pend && !reset;
    assign pop       = bus.m_valid && bus.m_ready;

    assign bus.mem_read_req  = issue;
    assign bus.mem_read_addr = addr;
    assign bus.m_valid       = !reset && (count != '0);
    assign bus.m_data        = fifo[rptr];
    // Only the final word of the transfer can be at the head while one word remains.
    assign bus.m_last        = bus.m_valid && (out_left == LEN_WIDTH'(1));
    assign busy              = !reset && (state != IDLE);
    assign done              = !reset && (state == FINISH);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = (num_words == '0) ? FINISH : ISSUE;
            ISSUE: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (issue_left == LEN_WIDTH'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN:  if (pop && bus.m_last) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            issue_left <= '0;
            out_left   <= '0;
            rd_pend    <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;
            if (state == IDLE && start) begin
                addr       <= base_addr;
                issue_left <= num_words;
                out_left   <= num_words;
            end
            if (issue) begin
                addr       <= addr + MEM_ADDR_WIDTH'(1);
                issue_left <= issue_left - LEN_WIDTH'(1);
            end
            if (push) wptr <= wptr + PW'(1);
            if (pop) begin
                rptr     <= rptr + PW'(1);
                out_left <= out_left - LEN_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= bus.mem_read_data;
    end
endmodule
